mul_share_ctrl: RTL and testbench

- Sequences the shared signed 6x6 sequential multiplier and arbitrates it between two requesters with round-robin priority.
- Per operation: latches the winner's operands, pulses the multiplier's `rst`, holds its `start` for a fixed run length, captures the 12-bit product and sign, and returns them to the winner with a one-cycle done pulse.
- Sits between the ALU front-end requesters and the multiplier instance.

---
 rtl/mul_share_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_mul_share_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_ctrl.sv
// Purpose : round-robin arbiter and sequencer sharing one signed sequential multiplier between two requesters.
// Latency : done<n> rises after the (MUL_LATENCY+2)th edge following the grant edge; grants are MUL_LATENCY+4 cycles apart.
// Backpressure: req<n> is a level held until done<n>; a losing or late request simply waits for IDLE.
//
// Ports:
//   clk, rst              - clock (rising edge) and asynchronous active-high reset
//   req0/a0/b0            - requester 0 request level and signed operands
//   done0/res0/neg0       - requester 0 completion pulse, product, product sign
//   req1/a1/b1            - requester 1 request level and signed operands
//   done1/res1/neg1       - requester 1 completion pulse, product, product sign
//   mul_rst/mul_start     - multiplier clear and run controls
//   mul_a/mul_b           - operands presented to the multiplier
//   mul_c/mul_neg         - product and sign returned by the multiplier
//   busy                  - controller is not idle
//   owner                 - requester granted most recently
module mul_share_ctrl #(
    parameter int WIDTH       = 6,
    parameter int MUL_LATENCY = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    output logic                 done0,
    output logic [2*WIDTH-1:0]   res0,
    output logic                 neg0,
    input  logic                 req1,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic                 done1,
    output logic [2*WIDTH-1:0]   res1,
    output logic                 neg1,
    output logic                 mul_rst,
    output logic                 mul_start,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_c,
    input  logic                 mul_neg,
    output logic                 busy,
    output logic                 owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(MUL_LATENCY - 1);

    state_t               state_q, state_d;
    logic                 ptr_q, ptr_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 owner_q, owner_d;
    logic [WIDTH-1:0]     mul_a_q, mul_a_d;
    logic [WIDTH-1:0]     mul_b_q, mul_b_d;
    logic                 mul_rst_q, mul_rst_d;
    logic                 mul_start_q, mul_start_d;
    logic                 busy_q, busy_d;
    logic                 done0_q, done0_d;
    logic                 done1_q, done1_d;
    logic [2*WIDTH-1:0]   res0_q, res0_d;
    logic [2*WIDTH-1:0]   res1_q, res1_d;
    logic                 neg0_q, neg0_d;
    logic                 neg1_q, neg1_d;
    logic                 win;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_rst_d   = 1'b0;
        mul_start_d = 1'b0;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        res0_d      = res0_q;
        res1_d      = res1_q;
        neg0_d      = neg0_q;
        neg1_d      = neg1_q;
        win         = 1'b0;

        case (state_q)
            IDLE: begin
                // The first edge out of reset only drops mul_rst; grants wait for it to be low.
                if (!mul_rst_q && (req0 || req1)) begin
                    win     = (req0 && req1) ? ptr_q : req1;
                    owner_d = win;
                    mul_a_d = win ? a1 : a0;
                    mul_b_d = win ? b1 : b0;
                    ptr_d   = ~win;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                mul_rst_d = 1'b1;
                cnt_d     = 8'd0;
                state_d   = RUN;
            end
            RUN: begin
                mul_start_d = 1'b1;
                // Count only edges that close a cycle with start already high, so the
                // multiplier sees exactly MUL_LATENCY start cycles before capture.
                if (mul_start_q) begin
                    if (cnt_q == LAST_CNT) begin
                        mul_start_d = 1'b0;
                        state_d     = DONE;
                        if (owner_q) begin
                            res1_d  = mul_c;
                            neg1_d  = mul_neg;
                            done1_d = 1'b1;
                        end else begin
                            res0_d  = mul_c;
                            neg0_d  = mul_neg;
                            done0_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            cnt_q       <= 8'd0;
            owner_q     <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_rst_q   <= 1'b1;
            mul_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            res0_q      <= '0;
            res1_q      <= '0;
            neg0_q      <= 1'b0;
            neg1_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_rst_q   <= mul_rst_d;
            mul_start_q <= mul_start_d;
            busy_q      <= busy_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            res0_q      <= res0_d;
            res1_q      <= res1_d;
            neg0_q      <= neg0_d;
            neg1_q      <= neg1_d;
        end
    end

    assign done0     = done0_q;
    assign res0      = res0_q;
    assign neg0      = neg0_q;
    assign done1     = done1_q;
    assign res1      = res1_q;
    assign neg1      = neg1_q;
    assign mul_rst   = mul_rst_q;
    assign mul_start = mul_start_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign busy      = busy_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Purpose : scoreboard bench for mul_share_ctrl with a behavioural 6x6 signed multiplier.
// Latency : expected products queued at issue, popped by a monitor on every done pulse.
// Backpressure: requests are held until the matching done, then dropped.
module tb_mul_share_ctrl;

    logic        clk;
    logic        rst;
    logic        req0, req1;
    logic [5:0]  a0, b0, a1, b1;
    logic        done0, done1;
    logic [11:0] res0, res1;
    logic        neg0, neg1;
    logic        mul_rst, mul_start;
    logic [5:0]  mul_a, mul_b;
    logic [11:0] mul_c;
    logic        mul_neg;
    logic        busy, owner;

    mul_share_ctrl #(.WIDTH(6), .MUL_LATENCY(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .done0(done0), .res0(res0), .neg0(neg0),
        .req1(req1), .a1(a1), .b1(b1), .done1(done1), .res1(res1), .neg1(neg1),
        .mul_rst(mul_rst), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_c(mul_c), .mul_neg(mul_neg), .busy(busy), .owner(owner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural multiplier: product appears once start has been high for 8 cycles.
    int unsigned       mcnt;
    logic signed [11:0] prod12;
    assign prod12  = $signed(mul_a) * $signed(mul_b);
    assign mul_c   = (mcnt >= 7) ? prod12 : 12'h000;
    assign mul_neg = mul_c[11];
    always @(posedge clk) begin
        if (mul_rst)                     mcnt <= 0;
        else if (mul_start && mcnt < 255) mcnt <= mcnt + 1;
    end

    int cyc;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [11:0] res;
        logic        neg;
    } exp_t;
    exp_t sb[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int id, input logic [11:0] r, input logic n);
        exp_t e;
        e.id = id; e.res = r; e.neg = n;
        sb.push_back(e);
    endtask

    // Monitor: every done pulse is matched against the next queued expectation.
    always @(negedge clk) begin
        if (done0 || done1) begin
            exp_t e;
            int   id;
            chk("done_exclusive", {31'd0, done0 & done1}, 32'd0);
            id = done1 ? 1 : 0;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got done%0d, expected no completion", id);
            end else begin
                e = sb.pop_front();
                chk("done_id", id, e.id);
                chk("done_owner", {31'd0, owner}, e.id);
                chk("result", id ? {20'd0, res1} : {20'd0, res0}, {20'd0, e.res});
                chk("sign", id ? {31'd0, neg1} : {31'd0, neg0}, {31'd0, e.neg});
            end
        end
    end

    // Returns on the negedge where busy is first seen (first cycle after the grant edge).
    task automatic wait_busy(input string nm);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy) break;
        end
        chk(nm, {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(input int id, input string nm);
        logic d;
        d = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            d = id ? done1 : done0;
            if (d) break;
        end
        chk(nm, {31'd0, d}, 32'd1);
        if (id) req1 = 1'b0; else req0 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rst_cnt, st_cnt, done_k, t0, t1, ndone;
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_mul_rst", {31'd0, mul_rst}, 32'd1);
        chk("rst_mul_start", {31'd0, mul_start}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_outputs", {20'd0, res0 | res1}, 32'd0);
        chk("rst_misc", {27'd0, done0, done1, neg0, neg1, owner}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("mul_rst_release", {31'd0, mul_rst}, 32'd1 - 32'd1);
        repeat (3) @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Single op, requester 0: 9 * -7 = -63
        a0 = 6'd9; b0 = 6'h39; req0 = 1'b1;
        push(0, 12'hFC1, 1'b1);
        wait_busy("grant_a");
        rst_cnt = 0; st_cnt = 0; done_k = -1;
        for (int k = 0; k <= 14; k++) begin
            if (k > 0) @(negedge clk);
            if (mul_rst)   rst_cnt++;
            if (mul_start) st_cnt++;
            if (done0) begin done_k = k; req0 = 1'b0; end
        end
        chk("a_mul_rst_cycles", rst_cnt, 1);
        chk("a_mul_start_cycles", st_cnt, 8);
        chk("a_done_cycle", done_k, 10);
        chk("a_res1_unchanged", {20'd0, res1}, 32'd0);

        // Simultaneous requests right after reset: requester 0 first.
        // 20 * 10 = 200 (40 is not a legal 6-bit signed operand).
        do_reset();
        a0 = 6'd20; b0 = 6'd10; a1 = 6'd9; b1 = 6'h39;
        req0 = 1'b1; req1 = 1'b1;
        push(0, 12'h0C8, 1'b0);
        push(1, 12'hFC1, 1'b1);
        t0 = -1; t1 = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done0) begin t0 = cyc; req0 = 1'b0; end
            if (done1) begin t1 = cyc; req1 = 1'b0; end
            if (t0 >= 0 && t1 >= 0) break;
        end
        chk("b_spacing", t1 - t0, 12);

        // Both held for four ops: alternate 0,1,0,1.
        repeat (2) @(negedge clk);
        a0 = 6'd3;  b0 = 6'h3E; a1 = 6'h20; b1 = 6'h20;
        push(0, 12'hFFA, 1'b1);
        push(1, 12'h400, 1'b0);
        push(0, 12'hFDD, 1'b1);
        push(1, 12'h3C1, 1'b0);
        req0 = 1'b1; req1 = 1'b1;
        ndone = 0;
        for (int i = 0; i < 80 && ndone < 4; i++) begin
            @(negedge clk);
            if (done0 || done1) begin
                chk("rr_owner_seq", {31'd0, owner}, ndone % 2);
                ndone++;
                if (ndone == 1) begin a0 = 6'h3B; b0 = 6'd7; end
                if (ndone == 2) begin a1 = 6'd31; b1 = 6'd31; end
                if (ndone == 4) begin req0 = 1'b0; req1 = 1'b0; end
            end
        end
        chk("rr_ops_done", ndone, 4);

        // Reset in the 4th RUN cycle aborts; next request needs two edges after release.
        repeat (2) @(negedge clk);
        a0 = 6'd5; b0 = 6'd5; req0 = 1'b1;
        wait_busy("grant_abort");
        repeat (5) @(negedge clk);
        chk("abort_running", {31'd0, mul_start}, 32'd1);
        rst = 1'b1; req0 = 1'b0;
        #1;
        chk("abort_mul_start", {31'd0, mul_start}, 32'd0);
        chk("abort_mul_rst", {31'd0, mul_rst}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_res", {8'd0, res0, res1}, 32'd0);
        chk("abort_neg", {30'd0, neg0, neg1}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        a1 = 6'd3; b1 = 6'd3; req1 = 1'b1;
        push(1, 12'h009, 1'b0);
        @(negedge clk);
        chk("post_rst_no_grant", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("post_rst_grant", {31'd0, busy}, 32'd1);
        wait_done(1, "post_rst_done1");

        // Request dropped and operand changed after grant: op still completes.
        repeat (2) @(negedge clk);
        a0 = 6'h3E; b0 = 6'd6; req0 = 1'b1;
        push(0, 12'hFF4, 1'b1);
        wait_busy("grant_drop");
        repeat (2) @(negedge clk);
        req0 = 1'b0; a0 = 6'd0;
        wait_done(0, "drop_done0");
        repeat (3) @(negedge clk);
        chk("idle_mul_a_held", {26'd0, mul_a}, {26'd0, 6'h3E});
        chk("idle_after_drop", {31'd0, busy}, 32'd0);

        repeat (5) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
